// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the elastic pipeline-stage register.
//                Holds the stage FSM encoding, the occupancy width and a
//                helper that maps a state to its occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        BUSY  = 2'd1,   // main entry valid, skid free
        FULL  = 2'd2    // main and skid both hold a bundle
    } pipe_state_t;

    // Number of bundles held in a given state.
    function automatic logic [OCC_W-1:0] state_occ(input pipe_state_t s);
        logic [OCC_W-1:0] occ;
        occ = 2'd0;
        case (s)
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage_if
//  Description : valid/ready/data handshake bundle between pipeline stages.
//                master drives valid+data and samples ready;
//                slave samples valid+data and drives ready.
//  Parameters  : WIDTH - payload width in bits
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stat_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stat_ctr
//  Description : Free-running statistics counter with enable. Wraps modulo
//                2^WIDTH, asynchronous active-high reset to zero.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active-high
//                en   - count enable for this cycle
//                cnt  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stat_ctr #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    output logic      [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Elastic pipeline-stage register with a one-entry skid
//                buffer. Accepts a bundle per cycle under a valid/ready
//                handshake; in_ready is registered so the ready path does
//                not chain combinationally through consecutive stages.
//  Parameters  : WIDTH     - payload width in bits
//                FLUSH_VAL - payload loaded on reset/flush (bubble encoding)
//  Ports       : CLK       - clock, rising edge
//                RST       - asynchronous reset, active-high
//                flush     - synchronous squash of all held entries
//                up        - upstream handshake (in_valid/in_ready/in_data)
//                dn        - downstream handshake (out_valid/out_ready/out_data)
//                occupancy - bundles currently held, 0..2
//                stall_cnt - cycles with out_valid & !out_ready  (stats only)
//                xfer_cnt  - downstream transfers                 (stats only)
//  Options     : PIPE_SKID_STATS_EN - adds stall_cnt / xfer_cnt outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              flush,
    pipe_skid_stage_if.slave       up,
    pipe_skid_stage_if.master      dn,
`ifdef PIPE_SKID_STATS_EN
    output logic      [31:0]       stall_cnt,
    output logic      [31:0]       xfer_cnt,
`endif
    output logic      [OCC_W-1:0]  occupancy
);

    pipe_state_t      state_q,    state_d;
    logic [WIDTH-1:0] main_q,     main_d;
    logic [WIDTH-1:0] skid_q,     skid_d;
    logic             in_ready_q, in_ready_d;

    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = up.valid & in_ready_q;
    assign out_fire  = out_valid & dn.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash wins: any same-cycle input is dropped, a same-cycle
            // output handshake has already been seen downstream.
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = up.data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d  = up.data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = up.data;
                    end else if (out_fire) begin
                        // main keeps its stale payload; hidden by out_valid=0
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                        skid_d  = FLUSH_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_VAL;
                    skid_d  = FLUSH_VAL;
                end
            endcase
        end

        // Ready is a pure function of the next state, so it is registered
        // and never looks at out_ready combinationally.
        in_ready_d = (state_d != FULL);
    end

    // in_ready_q resets low and only rises on the first edge after RST
    // releases, so nothing is accepted while the stage is being reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign up.ready  = in_ready_q;
    assign dn.valid  = out_valid;
    assign dn.data   = main_q;
    assign occupancy = state_occ(state_q);

`ifdef PIPE_SKID_STATS_EN
    // Counters only see RST; flush leaves them untouched.
    pipe_stat_ctr #(
        .WIDTH (32)
    ) u_stall_ctr (
        .clk (CLK),
        .rst (RST),
        .en  (out_valid & ~dn.ready),
        .cnt (stall_cnt)
    );

    pipe_stat_ctr #(
        .WIDTH (32)
    ) u_xfer_ctr (
        .clk (CLK),
        .rst (RST),
        .en  (out_fire),
        .cnt (xfer_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Self-checking bench for pipe_skid_stage. Directed vector
//                table, hand-written corner sequences (streaming, skid fill,
//                flush race, mid-operation reset), a randomised back-pressure
//                run with a scoreboard, and counter checks when
//                PIPE_SKID_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int               W  = 32;
    localparam logic [W-1:0]     FV = 32'hF1F1_0000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] xfer_cnt;
`endif

    pipe_skid_stage_if #(.WIDTH(W)) up_if ();
    pipe_skid_stage_if #(.WIDTH(W)) dn_if ();

    pipe_skid_stage #(
        .WIDTH     (W),
        .FLUSH_VAL (FV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
`ifdef PIPE_SKID_STATS_EN
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
        logic [1:0]   occ;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        up_if.valid = iv;
        up_if.data  = d;
        dn_if.ready = ordy;
        flush       = fl;
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [W-1:0] od,
                             input logic ir, input logic [1:0] occ);
        chk({tag, ".out_valid"}, {31'b0, dn_if.valid}, {31'b0, ov});
        chk({tag, ".out_data"},  dn_if.data, od);
        chk({tag, ".in_ready"},  {31'b0, up_if.ready}, {31'b0, ir});
        chk({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, occ});
    endtask

    initial begin
        logic [W-1:0] sb [$];
        logic [W-1:0] exp_val;
        logic [W-1:0] next_val;
        logic [W-1:0] held_data;
        logic         pending;
        logic         cur_iv;
        logic         cur_or;
        logic         stalled_prev;
        logic [W-1:0] data_prev;
`ifdef PIPE_SKID_STATS_EN
        logic [31:0]  s0;
        logic [31:0]  x0;
`endif

        // in_valid, in_data, out_ready, flush | out_valid, out_data, in_ready, occ
        vecs[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 2'd2};
        vecs[3]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 2'd2};
        vecs[4]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h3, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 32'h5, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 32'h6, 1'b0, 1'b0, 1'b1, 32'h5, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 32'h7, 1'b1, 1'b1, 1'b0, FV,    1'b1, 2'd0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, FV,    1'b1, 2'd0};
        vecs[12] = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b0, FV,    1'b1, 2'd0};

        // ---------------- power-on reset ----------------
        RST = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk_state("por", 1'b0, FV, 1'b0, 2'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        chk("por.ready_before_edge", {31'b0, up_if.ready}, 32'd0);
        step();
        chk_state("por_rel", 1'b0, FV, 1'b1, 2'd0);
`ifdef PIPE_SKID_STATS_EN
        chk("por.stall_cnt", stall_cnt, 32'd0);
        chk("por.xfer_cnt",  xfer_cnt,  32'd0);
`endif

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].occ);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // ---------------- streaming, zero bubbles ----------------
`ifdef PIPE_SKID_STATS_EN
        x0 = xfer_cnt;
`endif
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, W'(k), 1'b1, 1'b0);
            step();
            chk($sformatf("stream%0d.valid", k), {31'b0, dn_if.valid}, 32'd1);
            chk($sformatf("stream%0d.data", k), dn_if.data, W'(k));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("stream.drain_valid", {31'b0, dn_if.valid}, 32'd0);
`ifdef PIPE_SKID_STATS_EN
        chk("stream.xfer_delta", xfer_cnt - x0, 32'd8);
`endif

        // ---------------- skid fill and ordered drain ----------------
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        step();
        chk_state("skid_a", 1'b1, 32'h11, 1'b1, 2'd1);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        step();
        chk_state("skid_b", 1'b1, 32'h11, 1'b0, 2'd2);
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        chk_state("skid_hold", 1'b1, 32'h11, 1'b0, 2'd2);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk_state("skid_d1", 1'b1, 32'h22, 1'b1, 2'd1);
        step();
        chk_state("skid_d2", 1'b0, 32'h22, 1'b1, 2'd0);

        // ---------------- flush race in FULL ----------------
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        step();
        chk("race.occ_full", {30'b0, occupancy}, 32'd2);
        drive(1'b1, 32'h33, 1'b1, 1'b1);
        step();
        chk_state("race_flush", 1'b0, FV, 1'b1, 2'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk_state("race_after", 1'b0, FV, 1'b1, 2'd0);

        // ---------------- asynchronous reset mid-FULL ----------------
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        chk_state("rst_pre", 1'b1, 32'hA, 1'b0, 2'd2);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk_state("rst_async", 1'b0, FV, 1'b0, 2'd0);
        step();
        #1;
        RST = 1'b0;
        chk("rst.ready_held_low", {31'b0, up_if.ready}, 32'd0);
        step();
        chk_state("rst_rel", 1'b0, FV, 1'b1, 2'd0);
`ifdef PIPE_SKID_STATS_EN
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.xfer_cnt",  xfer_cnt,  32'd0);
`endif

        // ---------------- statistics ----------------
`ifdef PIPE_SKID_STATS_EN
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        step();
        s0 = stall_cnt;
        x0 = xfer_cnt;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (5) step();
        chk("stats.stall5", stall_cnt - s0, 32'd5);
        chk("stats.data_stable", dn_if.data, 32'h77);
        // One more stalled edge coincides with the flush; counters must
        // keep their totals rather than clear.
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        chk("stats.flush_stall", stall_cnt - s0, 32'd6);
        chk("stats.flush_xfer",  xfer_cnt - x0, 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
`endif

        // ---------------- random back-pressure with scoreboard ----------------
        next_val     = 32'h1000;
        held_data    = '0;
        pending      = 1'b0;
        cur_iv       = 1'b0;
        stalled_prev = 1'b0;
        data_prev    = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!pending) begin
                cur_iv    = ($urandom_range(0, 3) != 0);
                held_data = next_val;
            end
            cur_or = ($urandom_range(0, 2) != 0);
            drive(cur_iv, held_data, cur_or, 1'b0);
            // Outputs are registered, so sampling here is stable for this edge.
            if (cur_iv && up_if.ready) begin
                sb.push_back(held_data);
                next_val = next_val + 32'd1;
                pending  = 1'b0;
            end else begin
                pending  = cur_iv;
            end
            if (dn_if.valid && cur_or) begin
                if (sb.size() == 0) begin
                    chk("rand.sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_val = sb.pop_front();
                    chk("rand.sb_data", dn_if.data, exp_val);
                end
            end
            stalled_prev = dn_if.valid & ~cur_or;
            data_prev    = dn_if.data;
            step();
            if (stalled_prev) begin
                chk("rand.stall_valid",  {31'b0, dn_if.valid}, 32'd1);
                chk("rand.stall_stable", dn_if.data, data_prev);
            end
        end
        // Drain: at most two held entries remain.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            if (dn_if.valid) begin
                if (sb.size() == 0) begin
                    chk("drain.sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_val = sb.pop_front();
                    chk("drain.sb_data", dn_if.data, exp_val);
                end
            end
            step();
        end
        chk("rand.sb_empty", sb.size(), 32'd0);
        chk("rand.final_valid", {31'b0, dn_if.valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
